huff_encoder: RTL

HUFF_ENCODER -- requirements
Module: huff_encoder

---
 rtl/huff_encoder_if.sv | 30 +++
 rtl/huff_encoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/huff_encoder_if.sv
// Huffman encoder bus: code-table write port, character input
// handshake, and serial bitstream / status outputs.
interface huff_encoder_if;
    logic        tbl_we;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_code;
    logic [4:0]  tbl_len;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        serial_out;
    logic        serial_valid;
    logic        busy;
    logic        unmapped_err;
    logic [15:0] bits_sent;

    modport master (
        output tbl_we, tbl_addr, tbl_code, tbl_len,
        output char_in, char_valid,
        input  char_ready, serial_out, serial_valid,
        input  busy, unmapped_err, bits_sent
    );

    modport slave (
        input  tbl_we, tbl_addr, tbl_code, tbl_len,
        input  char_in, char_valid,
        output char_ready, serial_out, serial_valid,
        output busy, unmapped_err, bits_sent
    );
endinterface

// File: rtl/huff_encoder.sv
// Table-driven Huffman encoder: 256-entry code table, MSB-first
// serialiser with back-to-back codeword chaining.
module huff_encoder (
    input  logic           clk,
    input  logic           rst,
    huff_encoder_if.slave  bus
);
    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e      state_q, state_d;
    logic [255:0] vld_q, vld_d;
    logic [15:0] code_mem [256];
    logic [3:0]  lenm1_mem [256];

    logic [15:0] sh_q, sh_d;
    logic [3:0]  rem_q, rem_d;
    logic        sout_q, sout_d;
    logic        sval_q, sval_d;
    logic        uerr_q, uerr_d;
    logic [15:0] bits_q, bits_d;

    logic        len_ok;
    logic        hit_vld;
    logic [15:0] hit_code;
    logic [3:0]  hit_lm1;
    logic        ready;
    logic        accept;
    logic [3:0]  rem_dec;

    assign len_ok = (bus.tbl_len != 5'd0)
                 && (bus.tbl_len <= 5'd16);

    // Lookup reads pre-write contents on a same-edge table write
    assign hit_vld  = vld_q[bus.char_in];
    assign hit_code = code_mem[bus.char_in];
    assign hit_lm1  = lenm1_mem[bus.char_in];

    assign ready   = (state_q == S_IDLE) || (rem_q == 4'd0);
    assign accept  = bus.char_valid && ready;
    assign rem_dec = rem_q - 4'd1;

    always_comb begin
        vld_d = vld_q;
        if (bus.tbl_we) begin
            vld_d[bus.tbl_addr] = len_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.tbl_we && len_ok) begin
            code_mem[bus.tbl_addr]  <= bus.tbl_code;
            lenm1_mem[bus.tbl_addr] <= 4'(bus.tbl_len - 5'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        if (accept) begin
            state_d = hit_vld ? S_SHIFT : S_IDLE;
        end else if (state_q == S_SHIFT && rem_q != 4'd0) begin
            state_d = S_SHIFT;
        end
    end

    always_comb begin
        sh_d   = sh_q;
        rem_d  = 4'd0;
        sout_d = 1'b0;
        sval_d = 1'b0;
        uerr_d = 1'b0;
        if (accept) begin
            if (hit_vld) begin
                sh_d   = hit_code;
                rem_d  = hit_lm1;
                sout_d = hit_code[hit_lm1];
                sval_d = 1'b1;
            end else begin
                uerr_d = 1'b1;
            end
        end else if (state_q == S_SHIFT && rem_q != 4'd0) begin
            rem_d  = rem_dec;
            sout_d = sh_q[rem_dec];
            sval_d = 1'b1;
        end
        // Counts each bit at the edge it is launched onto serial_out
        bits_d = bits_q + {15'd0, sval_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            sh_q   <= '0;
            rem_q  <= '0;
            sout_q <= 1'b0;
            sval_q <= 1'b0;
            uerr_q <= 1'b0;
            bits_q <= '0;
        end else begin
            vld_q  <= vld_d;
            sh_q   <= sh_d;
            rem_q  <= rem_d;
            sout_q <= sout_d;
            sval_q <= sval_d;
            uerr_q <= uerr_d;
            bits_q <= bits_d;
        end
    end

    assign bus.char_ready   = ready;
    assign bus.serial_out   = sout_q;
    assign bus.serial_valid = sval_q;
    assign bus.busy         = (state_q == S_SHIFT);
    assign bus.unmapped_err = uerr_q;
    assign bus.bits_sent    = bits_q;
endmodule
